// File: rtl/spi_pkg.sv
// Shared SPI definitions: FSM state encoding and default timing parameters.
// Used by both the SPI master and the SPI slave.
package spi_pkg;

  localparam int CLK_DIV_DEFAULT = 25;
  localparam int WIDTH_DEFAULT   = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_XFER = 2'd1,
    ST_HOLD = 2'd2,
    ST_END  = 2'd3
  } spi_state_t;

endpackage

// File: rtl/spi_sclk_gen.sv
// SCLK half-period divider: produces one-cycle rise/fall strobes while run is high.
// The counter restarts from zero whenever run drops, so every frame starts phase-aligned.
module spi_sclk_gen
  import spi_pkg::*;
#(
  parameter int CLK_DIV = CLK_DIV_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  output logic rise_tick,
  output logic fall_tick
);

  localparam int CW = $clog2(CLK_DIV) + 1;

  logic [CW-1:0] cnt_r;
  logic          phase_r;
  logic          tick_s;

  // Strobe on the last cycle of each half-period; phase selects rise vs fall.
  always_comb begin
    tick_s    = run && (cnt_r == CW'(CLK_DIV - 1));
    rise_tick = tick_s && !phase_r;
    fall_tick = tick_s && phase_r;
  end

  // Half-period counter, reloaded on every edge strobe.
  always_ff @(posedge clk) begin
    if (rst || !run) begin
      cnt_r   <= '0;
      phase_r <= 1'b0;
    end else if (tick_s) begin
      cnt_r   <= '0;
      phase_r <= !phase_r;
    end else begin
      cnt_r   <= cnt_r + CW'(1);
      phase_r <= phase_r;
    end
  end

endmodule

// File: rtl/spi_master.sv
// Mode-0 SPI master: one WIDTH-bit frame per accepted start, MSB first,
// optional chip-select hold between back-to-back frames.
module spi_master
  import spi_pkg::*;
#(
  parameter int CLK_DIV = CLK_DIV_DEFAULT,
  parameter int WIDTH   = WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             hold_cs,
  input  logic [WIDTH-1:0] tx_data,
  output logic             ready,
  output logic             done,
  output logic [WIDTH-1:0] rx_data,
  output logic             sclk,
  output logic             mosi,
  input  logic             miso,
  output logic             cs
);

  localparam int BW = $clog2(WIDTH + 1);
  localparam int CW = $clog2(CLK_DIV) + 1;

  spi_state_t       state_r;
  logic [WIDTH-1:0] tx_sh_r;
  logic [WIDTH-1:0] rx_sh_r;
  logic [BW-1:0]    bit_cnt_r;
  logic [CW-1:0]    end_cnt_r;
  logic             hold_r;
  logic             run_s;
  logic             rise_tick_s;
  logic             fall_tick_s;

  assign run_s = (state_r == ST_XFER);

  spi_sclk_gen #(
    .CLK_DIV(CLK_DIV)
  ) u_sclk_gen (
    .clk      (clk),
    .rst      (rst),
    .run      (run_s),
    .rise_tick(rise_tick_s),
    .fall_tick(fall_tick_s)
  );

  // Frame control FSM with all interface outputs registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= ST_IDLE;
      cs        <= 1'b1;
      sclk      <= 1'b0;
      mosi      <= 1'b0;
      ready     <= 1'b1;
      done      <= 1'b0;
      rx_data   <= '0;
      tx_sh_r   <= '0;
      rx_sh_r   <= '0;
      bit_cnt_r <= '0;
      end_cnt_r <= '0;
      hold_r    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state_r)
        ST_IDLE, ST_HOLD: begin
          if (start) begin
            state_r   <= ST_XFER;
            ready     <= 1'b0;
            cs        <= 1'b0;
            tx_sh_r   <= tx_data;
            mosi      <= tx_data[WIDTH-1];
            hold_r    <= hold_cs;
            bit_cnt_r <= '0;
          end else if ((state_r == ST_HOLD) && !hold_cs) begin
            state_r   <= ST_END;
            ready     <= 1'b0;
            end_cnt_r <= '0;
          end else begin
            state_r <= state_r;
          end
        end
        ST_XFER: begin
          if (rise_tick_s) begin
            sclk      <= 1'b1;
            rx_sh_r   <= {rx_sh_r[WIDTH-2:0], miso};
            bit_cnt_r <= bit_cnt_r + BW'(1);
          end else if (fall_tick_s) begin
            sclk <= 1'b0;
            if (bit_cnt_r == BW'(WIDTH)) begin
              // Last falling edge: publish the frame; cs rises one cycle later via END.
              done      <= 1'b1;
              rx_data   <= rx_sh_r;
              mosi      <= 1'b0;
              end_cnt_r <= '0;
              if (hold_r) begin
                state_r <= ST_HOLD;
                ready   <= 1'b1;
              end else begin
                state_r <= ST_END;
              end
            end else begin
              tx_sh_r <= tx_sh_r << 1;
              mosi    <= tx_sh_r[WIDTH-2];
            end
          end else begin
            sclk <= sclk;
          end
        end
        ST_END: begin
          cs <= 1'b1;
          if (end_cnt_r == CW'(CLK_DIV)) begin
            state_r <= ST_IDLE;
            ready   <= 1'b1;
          end else begin
            end_cnt_r <= end_cnt_r + CW'(1);
          end
        end
        default: begin
          state_r <= ST_IDLE;
          ready   <= 1'b1;
          cs      <= 1'b1;
          sclk    <= 1'b0;
          mosi    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_master.sv
// Bench for spi_master: timeline-based reference model checked every cycle,
// directed frame scenarios with literal expectations, and a randomized phase.
module tb_spi_master;

  localparam int D  = 25;
  localparam int W  = 8;
  localparam int FL = 2 * W * D + 1;

  logic clk = 1'b0;
  logic rst, start, hold_cs, miso;
  logic [W-1:0] tx_data, rx_data;
  logic ready, done, sclk, mosi, cs;

  logic rst2, start2;
  logic [W-1:0] tx2, rx2;
  logic ready2, done2, sclk2, mosi2, cs2;

  int checks = 0;
  int errors = 0;

  logic loop_en = 1'b0;
  logic want_loop;
  logic force_en;
  logic [W-1:0] force_word;
  logic [W-1:0] s_word = '0;
  logic [2:0] s_idx;

  initial forever #5 clk = ~clk;

  spi_master dut (
    .clk(clk), .rst(rst), .start(start), .hold_cs(hold_cs), .tx_data(tx_data),
    .ready(ready), .done(done), .rx_data(rx_data), .sclk(sclk), .mosi(mosi),
    .miso(miso), .cs(cs)
  );

  spi_master #(.CLK_DIV(2), .WIDTH(8)) dut2 (
    .clk(clk), .rst(rst2), .start(start2), .hold_cs(1'b0), .tx_data(tx2),
    .ready(ready2), .done(done2), .rx_data(rx2), .sclk(sclk2), .mosi(mosi2),
    .miso(mosi2), .cs(cs2)
  );

  // Mode-0 slave: presents MSB while selected, advances on each sclk fall.
  assign miso = loop_en ? mosi : s_word[3'd7 - s_idx];

  initial begin
    s_idx = 3'd0;
    forever begin
      @(negedge sclk or posedge cs);
      if (cs) s_idx = 3'd0;
      else    s_idx = s_idx + 3'd1;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: expected outputs as a function of the cycle offset from acceptance.
  initial begin : model
    int n, fa, end_s, t, k;
    bit fa_v, fhold, in_hold, model_on;
    logic [W-1:0] ftx, fexp, exp_rx, tmp;
    logic e_sclk, e_mosi, e_cs, e_ready, e_done;
    n = 0; fa = 0; end_s = -1000; fa_v = 0; fhold = 0; in_hold = 0; model_on = 0;
    ftx = '0; fexp = '0; exp_rx = '0;
    forever begin
      @(negedge clk);
      n++;
      e_sclk = 1'b0; e_mosi = 1'b0; e_cs = 1'b1; e_ready = 1'b1; e_done = 1'b0;
      t = n - fa;
      if (fa_v && t >= 1 && t <= FL) begin
        e_cs    = 1'b0;
        e_done  = (t == FL);
        e_ready = (t == FL) ? fhold : 1'b0;
        if (t < FL) begin
          e_sclk = (((t - 1) / D) % 2) == 1;
          k      = (t - 1) / (2 * D);
          tmp    = ftx >> (W - 1 - k);
          e_mosi = tmp[0];
        end else begin
          exp_rx = fexp;
        end
      end else if (in_hold) begin
        e_cs = 1'b0;
      end else if (n >= end_s && n <= end_s + D) begin
        e_cs    = (n == end_s) ? 1'b0 : 1'b1;
        e_ready = 1'b0;
      end
      if (model_on) begin
        check("sclk",    32'(sclk),    32'(e_sclk));
        check("mosi",    32'(mosi),    32'(e_mosi));
        check("cs",      32'(cs),      32'(e_cs));
        check("ready",   32'(ready),   32'(e_ready));
        check("done",    32'(done),    32'(e_done));
        check("rx_data", 32'(rx_data), 32'(exp_rx));
      end
      if (rst) begin
        model_on = 1; fa_v = 0; in_hold = 0; end_s = -1000; exp_rx = '0;
      end else begin
        if (fa_v && t == FL) begin
          fa_v = 0;
          if (fhold) in_hold = 1;
          else       end_s = n;
        end
        if (e_ready && start) begin
          fa_v = 1; fa = n; ftx = tx_data; fhold = hold_cs; in_hold = 0; end_s = -1000;
          loop_en = want_loop;
          s_word  = force_en ? force_word : W'($urandom());
          fexp    = want_loop ? tx_data : s_word;
        end else if (in_hold && !start && !hold_cs) begin
          in_hold = 0;
          end_s   = n + 1;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready();
    int c;
    c = 0;
    while (!ready && c < 200) begin
      tick();
      c++;
    end
    check("wait_ready", 32'(ready), 32'd1);
  endtask

  // Drives one frame from the current cycle; optional stray starts at cycles 50 and 200.
  task automatic run_frame(input logic [W-1:0] tx, input logic h, input bit stray,
                           output int done_at, output int rises, output bit cs_hi);
    int c;
    logic prev_s;
    start = 1'b1; tx_data = tx; hold_cs = h;
    done_at = -1; rises = 0; cs_hi = 0; prev_s = sclk; c = 0;
    while (done_at < 0 && c < 2000) begin
      tick();
      c++;
      if (stray && (c == 50 || c == 200)) begin
        start = 1'b1; tx_data = W'($urandom());
      end else begin
        start = 1'b0;
      end
      if (sclk && !prev_s) rises++;
      prev_s = sclk;
      if (cs) cs_hi = 1;
      if (done) done_at = c;
    end
    start = 1'b0;
  endtask

  initial begin : driver
    int done_at, rises, c, hi_cnt, d2;
    bit cs_hi, cs_hi2, dn;
    rst = 1'b1; start = 1'b0; hold_cs = 1'b0; tx_data = '0;
    want_loop = 1'b0; force_en = 1'b0; force_word = '0;
    rst2 = 1'b1; start2 = 1'b0; tx2 = '0;
    repeat (3) tick();
    check("rst_cs",    32'(cs),      32'd1);
    check("rst_sclk",  32'(sclk),    32'd0);
    check("rst_mosi",  32'(mosi),    32'd0);
    check("rst_ready", 32'(ready),   32'd1);
    check("rst_done",  32'(done),    32'd0);
    check("rst_rx",    32'(rx_data), 32'd0);
    // start together with reset must be ignored
    start = 1'b1; tick(); start = 1'b0;
    check("start_in_rst", 32'(cs), 32'd1);
    rst = 1'b0; rst2 = 1'b0;
    tick();

    // CLK_DIV=2 loopback
    start2 = 1'b1; tx2 = 8'h81; d2 = -1; c = 0;
    while (d2 < 0 && c < 200) begin
      tick(); c++; start2 = 1'b0;
      if (done2) d2 = c;
    end
    check("div2_done_cycle", 32'(d2), 32'd33);
    check("div2_rx", 32'(rx2), 32'h81);

    // Loopback 0xA5
    want_loop = 1'b1;
    run_frame(8'hA5, 1'b0, 0, done_at, rises, cs_hi);
    check("lb_done_cycle", 32'(done_at), 32'd401);
    check("lb_rx", 32'(rx_data), 32'hA5);
    check("lb_rises", 32'(rises), 32'd8);
    tick();
    check("lb_cs_402", 32'(cs), 32'd1);

    // Slave returns 0x3C while master sends 0xFF
    wait_ready();
    want_loop = 1'b0; force_en = 1'b1; force_word = 8'h3C;
    run_frame(8'hFF, 1'b0, 0, done_at, rises, cs_hi);
    check("slave_rx", 32'(rx_data), 32'h3C);
    force_en = 1'b0;

    // Two frames under held chip select
    wait_ready();
    want_loop = 1'b1;
    run_frame(8'h12, 1'b1, 0, done_at, rises, cs_hi);
    check("hold_f1_done", 32'(done_at), 32'd401);
    check("hold_f1_rx", 32'(rx_data), 32'h12);
    run_frame(8'h34, 1'b0, 0, done_at, rises, cs_hi2);
    check("hold_f2_done", 32'(done_at), 32'd401);
    check("hold_f2_rx", 32'(rx_data), 32'h34);
    check("hold_cs_low", 32'(cs_hi || cs_hi2), 32'd0);
    hi_cnt = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (cs) hi_cnt++;
    end
    check("hold_deselect", 32'(hi_cnt), 32'd30);

    // Stray starts during a frame
    wait_ready();
    run_frame(8'h5A, 1'b0, 1, done_at, rises, cs_hi);
    check("stray_done_cycle", 32'(done_at), 32'd401);
    check("stray_rx", 32'(rx_data), 32'h5A);

    // Reset mid-frame at cycle 150
    wait_ready();
    start = 1'b1; tx_data = 8'hC3; hold_cs = 1'b0;
    for (int i = 1; i <= 150; i++) begin
      tick();
      start = 1'b0;
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort_cs", 32'(cs), 32'd1);
    check("abort_sclk", 32'(sclk), 32'd0);
    check("abort_ready", 32'(ready), 32'd1);
    dn = 0;
    for (int i = 0; i < 450; i++) begin
      tick();
      if (done) dn = 1;
    end
    check("abort_no_done", 32'(dn), 32'd0);
    check("abort_rx", 32'(rx_data), 32'd0);

    // Randomized traffic, checked cycle by cycle by the model
    for (int i = 0; i < 6000; i++) begin
      rst       = ($urandom_range(699, 0) == 0);
      start     = ($urandom_range(7, 0) == 0);
      hold_cs   = 1'($urandom_range(1, 0));
      tx_data   = W'($urandom());
      want_loop = 1'($urandom_range(1, 0));
      tick();
    end
    rst = 1'b0; start = 1'b0;
    repeat (3) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
